elastic_pipeline: RTL and testbench
===================================

ELASTIC_PIPELINE -- requirements
Module: elastic_pipeline

Interface
REQ-001 The block SHALL have parameter WIDTH, default 96, payload bits per stage; legal range is 1..1024.
REQ-002 The block SHALL have parameter DEPTH, default 2, number of register stages; legal range is 1..16.
REQ-003 The block SHALL have port clock, input, 1, the only clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous and active-high.
REQ-005 The block SHALL have port flush, input, 1, synchronous discard of all stage contents.
REQ-006 The block SHALL have port in_valid, input, 1, producer offers in_data.
REQ-007 The block SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH, payload.
REQ-009 The block SHALL have port out_valid, output, 1, last stage holds a payload.
REQ-010 The block SHALL have port out_ready, input, 1, consumer takes out_data.
REQ-011 The block SHALL have port out_data, output, WIDTH, last-stage payload.
REQ-012 The block SHALL have port occupancy, output, $clog2(DEPTH+1), count of valid stages.
REQ-013 The block SHALL have port stall_cycles, output, 32, back-pressure counter; present only under REQ-030.

Function
REQ-014 Each stage k (0..DEPTH-1) SHALL hold one valid bit and one WIDTH-bit data register; stage 0 is nearest the input, stage DEPTH-1 drives out_valid/out_data.
REQ-015 Transfer rule: input transfer = in_valid && in_ready; output transfer = out_valid && out_ready.
REQ-016 Stage DEPTH-1 SHALL be free when it is empty or on an output transfer; stage k<DEPTH-1 SHALL be free when it is empty or stage k+1 is free.
REQ-017 Stage k SHALL load from stage k-1 (or from in_data for k=0) exactly when it is free; its valid bit takes the upstream valid (input transfer for k=0).
REQ-018 in_ready SHALL equal (stage 0 free) && !flush; it may depend combinationally on out_ready.
REQ-019 Bubbles SHALL collapse: an empty stage always accepts from upstream regardless of downstream back-pressure.
REQ-020 Latency SHALL be exactly DEPTH cycles from input transfer to out_valid when out_ready is held high; throughput SHALL be one payload per cycle.
REQ-021 While out_valid && !out_ready, out_data SHALL remain stable and out_valid SHALL remain high.
REQ-022 Ordering SHALL be strictly FIFO; no payload is duplicated or dropped except by flush.
REQ-023 flush high at an edge SHALL clear every valid bit; no input transfer occurs that cycle; an output transfer signalled that cycle still counts at the consumer and is not repeated.
REQ-024 Data registers SHALL load only when their stage loads; flush SHALL NOT clear data registers.
REQ-025 occupancy SHALL be the registered population count of valid bits; full when occupancy = DEPTH, which with !out_ready forces in_ready low.

Reset
REQ-026 reset high SHALL immediately clear all valid bits, all data registers to 0, occupancy to 0, and stall_cycles to 0.
REQ-027 While reset is high, in_ready SHALL be 0 and out_valid SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight payloads; the first input transfer after reset deasserts SHALL be the first output.
REQ-029 Reset deassertion SHALL be synchronous to clock externally; the block adds no synchronizer.

Configuration
REQ-030 Macro ELASTIC_PIPELINE_STATS_EN defined: stall_cycles SHALL be present and increment by 1 on each edge with out_valid && !out_ready, saturate at 32'hFFFF_FFFF, clear only on reset (not flush).
REQ-031 Macro ELASTIC_PIPELINE_STATS_EN undefined: the stall_cycles port and counter SHALL NOT exist; all other behaviour is identical.

Verification
REQ-032 Streaming: DEPTH=2, out_ready=1, in_valid=1 for values 1..10 on consecutive cycles -> out_data 1..10 on consecutive cycles, first out_valid 2 cycles after first accept.
REQ-033 Back-pressure: DEPTH=3, out_ready=0, offer 5 payloads -> 3 accepted, occupancy=3, in_ready=0; out_ready=1 -> order preserved, no loss; stall_cycles equals stalled cycles with macro defined.
REQ-034 Bubble collapse: DEPTH=4, out_ready=0, payload A then 3 idle cycles -> A reaches the last stage; next payload B lands directly behind A; occupancy=2.
REQ-035 Flush: DEPTH=3 full, flush=1 one cycle with in_valid=1 -> next cycle occupancy=0, out_valid=0, the input offered during flush is not emitted.
REQ-036 Reset mid-stream: reset pulse at random cycle during REQ-032 traffic -> outputs 0 immediately; after release, the next accepted value is the first emitted.
REQ-037 Saturation, with macro defined: force the counter near max, hold out_valid && !out_ready -> stall_cycles holds 32'hFFFF_FFFF.

Source files
------------

// File: rtl/elastic_pipeline.sv
// ----------------------------------------------------------------------------
// elastic_pipeline
//   DEPTH-stage valid/ready register pipeline. A stage is free when it is empty
//   or when the stage below it is free, so an empty stage always accepts from
//   upstream. This is how bubbles collapse under back-pressure. The pipeline
//   keeps full throughput when out_ready is held high.
//
// Parameters
//   WIDTH  payload bits per stage (1..1024)
//   DEPTH  number of register stages (1..16)
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous, active-high; clears valid, data and counters
//   flush         synchronous discard of all stage valid bits
//   in_valid      producer offers in_data
//   in_ready      stage 0 free, not flushing, not in reset
//   in_data       payload in
//   out_valid     last stage holds a payload
//   out_ready     consumer takes out_data
//   out_data      last-stage payload
//   occupancy     registered count of valid stages
//   stall_cycles  saturating count of edges with out_valid && !out_ready
//                 (only when ELASTIC_PIPELINE_STATS_EN is defined)
// ----------------------------------------------------------------------------
module elastic_pipeline #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef ELASTIC_PIPELINE_STATS_EN
    ,
    output logic [31:0]                stall_cycles
`endif
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    if (WIDTH < 1 || WIDTH > 1024) begin : g_width_chk
        $error("elastic_pipeline: WIDTH out of range 1..1024");
    end
    if (DEPTH < 1 || DEPTH > 16) begin : g_depth_chk
        $error("elastic_pipeline: DEPTH out of range 1..16");
    end

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [OCC_W-1:0] r_occupancy;

    logic [DEPTH-1:0] w_free;
    logic [DEPTH-1:0] w_valid_next;
    logic [OCC_W-1:0] w_occ_next;
    logic             w_in_fire;

    // The free chain ripples from the output back toward the input. As a
    // result, in_ready depends combinationally on out_ready.
    always_comb begin
        w_free            = '0;
        w_free[DEPTH-1]   = !r_valid[DEPTH-1] || out_ready;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            w_free[DEPTH-1-i] = !r_valid[DEPTH-1-i] || w_free[DEPTH-i];
        end
    end

    assign in_ready  = w_free[0] && !flush && !reset;
    assign w_in_fire = in_valid && in_ready;

    always_comb begin
        w_valid_next    = r_valid;
        w_valid_next[0] = w_free[0] ? w_in_fire : r_valid[0];
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (w_free[i]) begin
                w_valid_next[i] = r_valid[i-1];
            end
        end
        if (flush) begin
            w_valid_next = '0;
        end
    end

    // occupancy is registered from the next-state valid bits. This keeps it
    // exactly aligned with r_valid and avoids a popcount on the output path.
    always_comb begin
        w_occ_next = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_occ_next = w_occ_next + OCC_W'(w_valid_next[i]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid     <= '0;
            r_occupancy <= '0;
        end else begin
            r_valid     <= w_valid_next;
            r_occupancy <= w_occ_next;
        end
    end

    // Data registers follow the load condition only. flush leaves them alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            if (w_free[0]) begin
                r_data[0] <= in_data;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (w_free[i]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];
    assign occupancy = r_occupancy;

`ifdef ELASTIC_PIPELINE_STATS_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (r_valid[DEPTH-1] && !out_ready && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_elastic_pipeline.sv
module tb_elastic_pipeline;

    logic        clock = 1'b0;
    logic        reset;

    logic        fl2, fl3, fl4;
    logic        v2, v3, v4;
    logic        rdy2, rdy3, rdy4;
    logic [15:0] d2, d3, d4;
    logic        ov2, ov3, ov4;
    logic        ordy2, ordy3, ordy4;
    logic [15:0] od2, od3, od4;
    logic [1:0]  occ2;
    logic [1:0]  occ3;
    logic [2:0]  occ4;
`ifdef ELASTIC_PIPELINE_STATS_EN
    logic [31:0] stall2, stall3, stall4;
`endif

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    logic [15:0] q2[$], q3[$], q4[$];
    int          t2[$];
    int          pc4[$];
    logic [31:0] stall3_exp;
    int          rst_at;

    always #5 clock = ~clock;

    elastic_pipeline #(.WIDTH(16), .DEPTH(2)) u2 (
        .clock(clock), .reset(reset), .flush(fl2),
        .in_valid(v2), .in_ready(rdy2), .in_data(d2),
        .out_valid(ov2), .out_ready(ordy2), .out_data(od2),
        .occupancy(occ2)
`ifdef ELASTIC_PIPELINE_STATS_EN
        , .stall_cycles(stall2)
`endif
    );

    elastic_pipeline #(.WIDTH(16), .DEPTH(3)) u3 (
        .clock(clock), .reset(reset), .flush(fl3),
        .in_valid(v3), .in_ready(rdy3), .in_data(d3),
        .out_valid(ov3), .out_ready(ordy3), .out_data(od3),
        .occupancy(occ3)
`ifdef ELASTIC_PIPELINE_STATS_EN
        , .stall_cycles(stall3)
`endif
    );

    elastic_pipeline #(.WIDTH(16), .DEPTH(4)) u4 (
        .clock(clock), .reset(reset), .flush(fl4),
        .in_valid(v4), .in_ready(rdy4), .in_data(d4),
        .out_valid(ov4), .out_ready(ordy4), .out_data(od4),
        .occupancy(occ4)
`ifdef ELASTIC_PIPELINE_STATS_EN
        , .stall_cycles(stall4)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_nonempty(input string tag, input int sz);
        total++;
        assert (sz > 0) else begin
            bad++;
            $error("FAIL %s observed=output_with_empty_scoreboard expected=no_output", tag);
        end
    endtask

    // One clock cycle. Entered at a negedge with inputs already driven. It
    // scores transfers before the edge and checks occupancy after the edge.
    task automatic tick();
        logic [15:0] e;
        int          t;
        #2;
        if (v2) chk("u2_in_ready_streaming", 64'(rdy2), 64'd1);
        if (v2 && rdy2) begin q2.push_back(d2); t2.push_back(cyc); end
        if (v3 && rdy3) q3.push_back(d3);
        if (v4 && rdy4) q4.push_back(d4);
        if (ov2 && ordy2) begin
            chk_nonempty("u2_unexpected_out", q2.size());
            if (q2.size() > 0) begin
                e = q2.pop_front();
                t = t2.pop_front();
                chk("u2_data", 64'(od2), 64'(e));
                chk("u2_latency", 64'(cyc - t), 64'd2);
            end
        end
        if (ov3 && ordy3) begin
            chk_nonempty("u3_unexpected_out", q3.size());
            if (q3.size() > 0) begin
                e = q3.pop_front();
                chk("u3_data", 64'(od3), 64'(e));
            end
        end
        if (ov4 && ordy4) begin
            chk_nonempty("u4_unexpected_out", q4.size());
            if (q4.size() > 0) begin
                e = q4.pop_front();
                chk("u4_data", 64'(od4), 64'(e));
                pc4.push_back(cyc);
            end
        end
        if (ov3 && !ordy3 && stall3_exp != 32'hFFFF_FFFF) stall3_exp++;
        if (fl3) q3.delete();
        @(posedge clock);
        #1;
        cyc++;
        chk("u2_occupancy", 64'(occ2), 64'(q2.size()));
        chk("u3_occupancy", 64'(occ3), 64'(q3.size()));
        chk("u4_occupancy", 64'(occ4), 64'(q4.size()));
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        {fl2, fl3, fl4} = '0;
        {v2, v3, v4} = '0;
        d2 = '0; d3 = '0; d4 = '0;
        ordy2 = 1'b1; ordy3 = 1'b0; ordy4 = 1'b0;
        stall3_exp = '0;

        // Reset state
        @(negedge clock);
        chk("rst_u2_in_ready", 64'(rdy2), 64'd0);
        chk("rst_u3_in_ready", 64'(rdy3), 64'd0);
        chk("rst_u2_out_valid", 64'(ov2), 64'd0);
        chk("rst_u4_out_valid", 64'(ov4), 64'd0);
        chk("rst_u3_occupancy", 64'(occ3), 64'd0);
        chk("rst_u4_out_data", 64'(od4), 64'd0);
`ifdef ELASTIC_PIPELINE_STATS_EN
        chk("rst_u3_stall", 64'(stall3), 64'd0);
`endif
        @(negedge clock);
        reset = 1'b0;

        // Streaming, DEPTH=2: 1..10 back to back
        for (int i = 1; i <= 10; i++) begin
            v2 = 1'b1; d2 = 16'(i);
            tick();
        end
        v2 = 1'b0;
        for (int n = 0; n < 10 && q2.size() > 0; n++) tick();
        chk("u2_stream_drained", 64'(q2.size()), 64'd0);

        // Back-pressure, DEPTH=3: 5 offers with out_ready low
        for (int i = 0; i < 5; i++) begin
            v3 = 1'b1; d3 = 16'(100 + i);
            tick();
        end
        chk("u3_bp_accepted", 64'(q3.size()), 64'd3);
        chk("u3_bp_occupancy", 64'(occ3), 64'd3);
        chk("u3_bp_in_ready", 64'(rdy3), 64'd0);
        chk("u3_bp_out_valid", 64'(ov3), 64'd1);
        chk("u3_bp_out_data_held", 64'(od3), 64'd100);
`ifdef ELASTIC_PIPELINE_STATS_EN
        chk("u3_bp_stall", 64'(stall3), 64'(stall3_exp));
        chk("u3_bp_stall_count", 64'(stall3), 64'd2);
`endif
        v3 = 1'b0; ordy3 = 1'b1;
        for (int n = 0; n < 10 && q3.size() > 0; n++) tick();
        chk("u3_bp_drained", 64'(q3.size()), 64'd0);

        // Bubble collapse, DEPTH=4: A then idle, then B behind it
        v4 = 1'b1; d4 = 16'hA0A0;
        tick();
        v4 = 1'b0;
        for (int n = 0; n < 3; n++) tick();
        chk("u4_A_out_valid", 64'(ov4), 64'd1);
        chk("u4_A_out_data", 64'(od4), 64'hA0A0);
        v4 = 1'b1; d4 = 16'hB0B0;
        tick();
        v4 = 1'b0;
        for (int n = 0; n < 3; n++) tick();
        chk("u4_bubble_occupancy", 64'(occ4), 64'd2);
        chk("u4_A_still_out", 64'(od4), 64'hA0A0);
        ordy4 = 1'b1;
        for (int n = 0; n < 10 && q4.size() > 0; n++) tick();
        chk("u4_drained", 64'(q4.size()), 64'd0);
        chk("u4_pop_count", 64'(pc4.size()), 64'd2);
        if (pc4.size() == 2) chk("u4_B_adjacent", 64'(pc4[1] - pc4[0]), 64'd1);

        // Flush, DEPTH=3 full
        ordy3 = 1'b0;
        for (int n = 0; n < 10 && occ3 != 2'd3; n++) begin
            v3 = 1'b1; d3 = 16'(200 + n);
            tick();
        end
        chk("u3_fill_occupancy", 64'(occ3), 64'd3);
        fl3 = 1'b1; v3 = 1'b1; d3 = 16'h0BAD;
        #1;
        chk("u3_flush_in_ready", 64'(rdy3), 64'd0);
        tick();
        fl3 = 1'b0; v3 = 1'b0;
        chk("u3_flush_occupancy", 64'(occ3), 64'd0);
        chk("u3_flush_out_valid", 64'(ov3), 64'd0);
        chk("u3_flush_keeps_data", 64'(od3), 64'd200);
`ifdef ELASTIC_PIPELINE_STATS_EN
        chk("u3_flush_stall", 64'(stall3), 64'(stall3_exp));
`endif
        ordy3 = 1'b1;
        for (int n = 0; n < 4; n++) tick();
        v3 = 1'b1; d3 = 16'h0C0C;
        tick();
        v3 = 1'b0;
        for (int n = 0; n < 10 && q3.size() > 0; n++) tick();
        chk("u3_post_flush_drained", 64'(q3.size()), 64'd0);

        // Reset mid-stream, DEPTH=2
        rst_at = int'($urandom_range(3, 8));
        for (int i = 1; i <= 10; i++) begin
            if (i == rst_at) begin
                v2 = 1'b0;
                reset = 1'b1;
                #1;
                chk("midrst_u2_out_valid", 64'(ov2), 64'd0);
                chk("midrst_u2_in_ready", 64'(rdy2), 64'd0);
                chk("midrst_u2_occupancy", 64'(occ2), 64'd0);
                chk("midrst_u2_out_data", 64'(od2), 64'd0);
                q2.delete(); t2.delete(); q3.delete(); q4.delete();
                stall3_exp = '0;
                @(posedge clock);
                @(negedge clock);
                reset = 1'b0;
            end
            v2 = 1'b1; d2 = 16'(300 + i);
            tick();
        end
        v2 = 1'b0;
        for (int n = 0; n < 10 && q2.size() > 0; n++) tick();
        chk("midrst_drained", 64'(q2.size()), 64'd0);

`ifdef ELASTIC_PIPELINE_STATS_EN
        // Saturation of the stall counter
        chk("midrst_u3_stall", 64'(stall3), 64'd0);
        force u3.r_stall_cycles = 32'hFFFF_FFFD;
        #1;
        release u3.r_stall_cycles;
        stall3_exp = 32'hFFFF_FFFD;
        ordy3 = 1'b0;
        v3 = 1'b1; d3 = 16'h5A5A;
        tick();
        v3 = 1'b0;
        for (int n = 0; n < 7; n++) tick();
        chk("sat_stall_model", 64'(stall3), 64'(stall3_exp));
        chk("sat_stall_max", 64'(stall3), 64'hFFFF_FFFF);
        ordy3 = 1'b1;
        for (int n = 0; n < 10 && q3.size() > 0; n++) tick();
        chk("sat_drained", 64'(q3.size()), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
